// File: rtl/pll_lock_reset_gen.sv
// pll_lock_reset_gen
//   Turns the PLL's asynchronous lock flag into a clean synchronous reset for the
//   PLL output clock domain. Release waits for a continuous-lock window. A
//   filtered loss of lock puts the domain back into reset. Each loss is recorded
//   in a sticky flag and in a saturating counter.
//
// Ports
//   clk          PLL output clock, the only clock
//   reset        synchronous active-high block reset
//   pll_locked   PLL lock flag, asynchronous to clk
//   force_reset  synchronous request to re-enter reset (not counted as a loss)
//   clear_sticky one-cycle pulse that clears lock_lost
//   sys_reset    synchronous active-high reset for downstream logic
//   ready        high exactly in RUN
//   lock_lost    sticky lock-loss flag
//   loss_count   saturating count of lock-loss events
//   state_dbg    0=RESET_HOLD 1=WAIT_LOCK 2=STABILIZE 3=RUN
module pll_lock_reset_gen #(
  parameter int SYNC_STAGES        = 2,
  parameter int MIN_RESET_CYCLES   = 16,
  parameter int LOCK_STABLE_CYCLES = 200,
  parameter int LOSS_FILTER        = 4,
  parameter int LOSS_CNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pll_locked,
  input  logic                      force_reset,
  input  logic                      clear_sticky,
  output logic                      sys_reset,
  output logic                      ready,
  output logic                      lock_lost,
  output logic [LOSS_CNT_WIDTH-1:0] loss_count,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    WAIT_LOCK  = 2'd1,
    STABILIZE  = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam int HW = $clog2(MIN_RESET_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int FW = $clog2(LOSS_FILTER + 1);

  localparam logic [HW-1:0] HOLD_LAST   = HW'(MIN_RESET_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST   = FW'(LOSS_FILTER - 1);

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     lock_s;
  logic [HW-1:0]            hold_q, hold_d;
  logic [SW-1:0]            stable_q, stable_d;
  logic [FW-1:0]            filt_q, filt_d;
  logic                     loss_evt;

  // Lock synchronizer: bit 0 samples the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RESET_HOLD;
      hold_q   <= '0;
      stable_q <= '0;
      filt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      stable_q <= stable_d;
      filt_q   <= filt_d;
    end
  end

  // Each counter is live only in its own state. It defaults to zero, so it
  // starts from zero whenever its state is entered, whatever the entry path.
  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    stable_d = '0;
    filt_d   = '0;
    loss_evt = 1'b0;
    if (force_reset) begin
      state_d = RESET_HOLD;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (hold_q == HOLD_LAST) state_d = WAIT_LOCK;
          else                     hold_d  = hold_q + 1'b1;
        end
        WAIT_LOCK: begin
          if (lock_s) state_d = STABILIZE;
        end
        STABILIZE: begin
          if (!lock_s)                    state_d  = WAIT_LOCK;
          else if (stable_q == STABLE_LAST) state_d = RUN;
          else                            stable_d = stable_q + 1'b1;
        end
        RUN: begin
          if (!lock_s) begin
            if (filt_q == FILT_LAST) begin
              state_d  = RESET_HOLD;
              loss_evt = 1'b1;
            end else begin
              filt_d = filt_q + 1'b1;
            end
          end
        end
        default: state_d = RESET_HOLD;
      endcase
    end
  end

  // When a loss and clear_sticky arrive on the same edge, the loss wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      if (loss_evt)          lock_lost <= 1'b1;
      else if (clear_sticky) lock_lost <= 1'b0;
      if (loss_evt && (loss_count != {LOSS_CNT_WIDTH{1'b1}}))
        loss_count <= loss_count + 1'b1;
    end
  end

  // Outputs are decoded from registered state only.
  assign sys_reset = (state_q != RUN);
  assign ready     = (state_q == RUN);
  assign state_dbg = state_q;

endmodule
